// File: rtl/fpu_pkg.sv
// fpu_pkg: shared op encodings, stage record and helpers
// for the FPU control pipeline (fpu_pipe_ctrl, fpu_iter_seq).
package fpu_pkg;

  localparam int REG_W = 5;
  localparam int OP_W  = 3;

  localparam logic [OP_W-1:0] FOP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] FOP_SUB  = 3'b001;
  localparam logic [OP_W-1:0] FOP_MUL  = 3'b010;
  localparam logic [OP_W-1:0] FOP_DIV  = 3'b100;
  localparam logic [OP_W-1:0] FOP_SQRT = 3'b110;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_ITER = 1'b1
  } iter_state_e;

  typedef struct packed {
    logic             w;
    logic [OP_W-1:0]  c;
    logic [REG_W-1:0] n;
  } stage_t;

  // fdiv (10x) and fsqrt (11x) are iterative
  function automatic logic is_iter(
    input logic [OP_W-1:0] fc
  );
    return fc[2];
  endfunction

endpackage

// File: rtl/fpu_iter_seq.sv
// fpu_iter_seq: RUN/ITER sequencer for iterative fdiv/fsqrt in E1.
// Ports: i_load (op captured into E1), i_n (occupancy-1);
//   o_busy (ITER), o_iter_start (1-cycle pulse), o_iter_cnt.
module fpu_iter_seq
  import fpu_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_n,
  output logic             o_busy,
  output logic             o_iter_start,
  output logic [CNT_W-1:0] o_iter_cnt
);

  iter_state_e      r_state;
  iter_state_e      w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_start;
  logic             w_start_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
      r_start <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_start <= w_start_nxt;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_cnt_nxt   = r_cnt;
    w_start_nxt = 1'b0;
    unique case (r_state)
      S_RUN: begin
        w_cnt_nxt = '0;
        if (i_load) begin
          w_cnt_nxt   = i_n;
          w_start_nxt = 1'b1;
          // single-cycle ops never leave RUN
          if (i_n != '0)
            w_next = S_ITER;
        end
      end
      S_ITER: begin
        if (r_cnt != '0)
          w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt <= CNT_W'(1))
          w_next = S_RUN;
      end
      default: w_next = S_RUN;
    endcase
  end

  assign o_busy       = (r_state == S_ITER);
  assign o_iter_start = r_start;
  assign o_iter_cnt   = r_cnt;

endmodule

// File: rtl/fpu_pipe_ctrl.sv
// fpu_pipe_ctrl: FPU control pipeline E1/E2/E3/WB fed by IU issue
// (fc,wf,fd); exports e*n/e*w/e*c, wn/ww, div/sqrt stall + iter ctl.
module fpu_pipe_ctrl
  import fpu_pkg::*;
#(
  parameter int DIV_CYCLES  = 14,
  parameter int SQRT_CYCLES = 14,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  fc,
  input  logic             wf,
  input  logic [REG_W-1:0] fd,
  output logic [REG_W-1:0] e1n,
  output logic [REG_W-1:0] e2n,
  output logic [REG_W-1:0] e3n,
  output logic             e1w,
  output logic             e2w,
  output logic             e3w,
  output logic [OP_W-1:0]  e1c,
  output logic [OP_W-1:0]  e2c,
  output logic [OP_W-1:0]  e3c,
  output logic [REG_W-1:0] wn,
  output logic             ww,
  output logic             stall_div_sqrt,
  output logic             iter_start,
  output logic [CNT_W-1:0] iter_cnt
);

  localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] SQRT_M1 = CNT_W'(SQRT_CYCLES - 1);

  stage_t           r_e1;
  stage_t           r_e2;
  stage_t           r_e3;
  stage_t           r_wb;
  stage_t           w_in;
  stage_t           w_bub;
  logic             w_busy;
  logic             w_load;
  logic [CNT_W-1:0] w_n;

  assign w_in   = '{w: wf, c: fc, n: fd};
  assign w_bub  = '{w: 1'b0, c: r_e1.c, n: r_e1.n};
  // sequencer only acts on load while in RUN
  assign w_load = wf & is_iter(fc);
  assign w_n    = fc[1] ? SQRT_M1 : DIV_M1;

  fpu_iter_seq #(
    .CNT_W(CNT_W)
  ) u_seq (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_load),
    .i_n          (w_n),
    .o_busy       (w_busy),
    .o_iter_start (iter_start),
    .o_iter_cnt   (iter_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_e1 <= '0;
      r_e2 <= '0;
      r_e3 <= '0;
      r_wb <= '0;
    end else begin
      r_e3 <= r_e2;
      r_wb <= r_e3;
      if (w_busy) begin
        // E1 frozen; E2 takes a bubble
        r_e2 <= w_bub;
      end else begin
        r_e2 <= r_e1;
        r_e1 <= w_in;
      end
    end
  end

  assign e1n = r_e1.n;
  assign e2n = r_e2.n;
  assign e3n = r_e3.n;
  assign e1w = r_e1.w;
  assign e2w = r_e2.w;
  assign e3w = r_e3.w;
  assign e1c = r_e1.c;
  assign e2c = r_e2.c;
  assign e3c = r_e3.c;
  assign wn  = r_wb.n;
  assign ww  = r_wb.w;

  assign stall_div_sqrt = w_busy;

endmodule

// File: tb/tb_fpu_pipe_ctrl.sv
// tb_fpu_pipe_ctrl: directed bench for fpu_pipe_ctrl
// (DIV_CYCLES=4, SQRT_CYCLES=6).
module tb_fpu_pipe_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] fc;
  logic       wf;
  logic [4:0] fd;
  logic [4:0] e1n, e2n, e3n, wn;
  logic       e1w, e2w, e3w, ww;
  logic [2:0] e1c, e2c, e3c;
  logic       stall;
  logic       istart;
  logic [3:0] icnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fpu_pipe_ctrl #(
    .DIV_CYCLES (4),
    .SQRT_CYCLES(6),
    .CNT_W      (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fc            (fc),
    .wf            (wf),
    .fd            (fd),
    .e1n           (e1n),
    .e2n           (e2n),
    .e3n           (e3n),
    .e1w           (e1w),
    .e2w           (e2w),
    .e3w           (e3w),
    .e1c           (e1c),
    .e2c           (e2c),
    .e3c           (e3c),
    .wn            (wn),
    .ww            (ww),
    .stall_div_sqrt(stall),
    .iter_start    (istart),
    .iter_cnt      (icnt)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(
    input logic [2:0] c,
    input logic       w,
    input logic [4:0] d
  );
    fc = c;
    wf = w;
    fd = d;
  endtask

  task automatic drain(input int n);
    issue(3'b000, 1'b0, 5'd0);
    for (int i = 0; i < n; i++)
      step();
  endtask

  logic saw;

  initial begin
    reset = 1'b1;
    issue(3'b000, 1'b0, 5'd0);
    step();
    step();
    chk("rst_e1w", e1w, 0);
    chk("rst_e2w", e2w, 0);
    chk("rst_e3w", e3w, 0);
    chk("rst_ww", ww, 0);
    chk("rst_stall", stall, 0);
    chk("rst_start", istart, 0);
    chk("rst_cnt", icnt, 0);
    chk("rst_e1n", e1n, 0);
    reset = 1'b0;

    // fadd fd=3
    issue(3'b000, 1'b1, 5'd3);
    step();
    issue(3'b000, 1'b0, 5'd0);
    chk("add_c1_e1n", e1n, 3);
    chk("add_c1_e1w", e1w, 1);
    chk("add_c1_stall", stall, 0);
    step();
    chk("add_c2_e2w", e2w, 1);
    chk("add_c2_stall", stall, 0);
    step();
    chk("add_c3_e3w", e3w, 1);
    chk("add_c3_ww", ww, 0);
    step();
    chk("add_c4_ww", ww, 1);
    chk("add_c4_wn", wn, 3);
    drain(4);

    // fdiv fd=7
    issue(3'b100, 1'b1, 5'd7);
    step();
    issue(3'b000, 1'b0, 5'd0);
    chk("div_c1_start", istart, 1);
    chk("div_c1_stall", stall, 1);
    chk("div_c1_cnt", icnt, 3);
    step();
    chk("div_c2_start", istart, 0);
    chk("div_c2_stall", stall, 1);
    chk("div_c2_cnt", icnt, 2);
    chk("div_c2_e2w", e2w, 0);
    step();
    chk("div_c3_stall", stall, 1);
    chk("div_c3_cnt", icnt, 1);
    step();
    chk("div_c4_stall", stall, 0);
    chk("div_c4_cnt", icnt, 0);
    chk("div_c4_e1n", e1n, 7);
    chk("div_c4_e2w", e2w, 0);
    step();
    chk("div_c5_e2w", e2w, 1);
    chk("div_c5_e2n", e2n, 7);
    chk("div_c5_e2c", e2c, 3'b100);
    step();
    chk("div_c6_e3w", e3w, 1);
    chk("div_c6_ww", ww, 0);
    step();
    chk("div_c7_ww", ww, 1);
    chk("div_c7_wn", wn, 7);
    drain(4);

    // fmul fd=2 then fsqrt fd=9
    issue(3'b010, 1'b1, 5'd2);
    step();
    issue(3'b110, 1'b1, 5'd9);
    chk("ms_c1_e1n", e1n, 2);
    step();
    issue(3'b000, 1'b0, 5'd0);
    chk("ms_c2_start", istart, 1);
    chk("ms_c2_stall", stall, 1);
    chk("ms_c2_cnt", icnt, 5);
    chk("ms_c2_e2n", e2n, 2);
    chk("ms_c2_e2w", e2w, 1);
    for (int c = 3; c <= 10; c++) begin
      step();
      chk($sformatf("ms_c%0d_stall", c), stall, (c <= 6) ? 1 : 0);
      chk($sformatf("ms_c%0d_e2w", c), e2w, (c == 8) ? 1 : 0);
      chk($sformatf("ms_c%0d_ww", c), ww, (c == 4 || c == 10) ? 1 : 0);
      if (c == 4)
        chk("ms_c4_wn", wn, 2);
      if (c == 10)
        chk("ms_c10_wn", wn, 9);
    end
    drain(4);

    // fdiv fd=4 then held fsqrt fd=5
    issue(3'b100, 1'b1, 5'd4);
    step();
    issue(3'b110, 1'b1, 5'd5);
    chk("bb_c1_start", istart, 1);
    step();
    chk("bb_c2_start", istart, 0);
    step();
    chk("bb_c3_stall", stall, 1);
    step();
    chk("bb_c4_stall", stall, 0);
    chk("bb_c4_start", istart, 0);
    step();
    issue(3'b000, 1'b0, 5'd0);
    chk("bb_c5_start", istart, 1);
    chk("bb_c5_stall", stall, 1);
    chk("bb_c5_cnt", icnt, 5);
    chk("bb_c5_e1n", e1n, 5);
    chk("bb_c5_e2n", e2n, 4);
    chk("bb_c5_e2w", e2w, 1);
    drain(12);

    // reset during fdiv fd=7
    issue(3'b100, 1'b1, 5'd7);
    step();
    issue(3'b000, 1'b0, 5'd0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rs_c3_stall", stall, 0);
    chk("rs_c3_cnt", icnt, 0);
    chk("rs_c3_e1w", e1w, 0);
    chk("rs_c3_e2w", e2w, 0);
    chk("rs_c3_e3w", e3w, 0);
    chk("rs_c3_ww", ww, 0);
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ww)
        saw = 1'b1;
    end
    chk("rs_no_ww", saw, 0);

    // bubbles with iterative op codes
    issue(3'b011, 1'b0, 5'd12);
    step();
    chk("bub_e1w", e1w, 0);
    chk("bub_e1n", e1n, 12);
    chk("bub_stall", stall, 0);
    chk("bub_start", istart, 0);
    issue(3'b100, 1'b0, 5'd13);
    step();
    issue(3'b000, 1'b0, 5'd0);
    chk("bubd_stall", stall, 0);
    chk("bubd_start", istart, 0);
    chk("bubd_cnt", icnt, 0);
    step();
    chk("bubd_stall2", stall, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
